cmp_pair_sequencer: RTL and testbench
=====================================

# cmp_pair_sequencer

Sequential initiator for the `comparator_nbit` interface. It accepts operand pairs from a host over a valid/ready handshake and buffers them in a small FIFO. Each pair is driven onto the comparator's `a`/`b` inputs and held for a programmable settle time. The block then samples `Lesser`/`Greater`/`Equal`, checks them against an internal unsigned compare, and returns the flags plus an error bit over a second valid/ready handshake. It also keeps saturating per-outcome statistics, and it replaces hand-written stimulus with a reusable hardware driver/checker.

## Interface
- `N`, 32, operand width
- `DEPTH`, 4, input FIFO depth; power of two, ≥2
- `SETTLE`, 2, cycles operands are held before flags are sampled; ≥1
- `CW`, 16, statistics counter width
- `clk` input 1: rising-edge clock; the block has one clock
- `rst_n` input 1: reset, asynchronous and active-low
- `in_valid` input 1: host offers a pair
- `in_ready` output 1: FIFO not full
- `in_a` input N: operand a
- `in_b` input N: operand b
- `cmp_a` output N: to comparator `a`
- `cmp_b` output N: to comparator `b`
- `cmp_lesser` input 1: from comparator `Lesser`
- `cmp_greater` input 1: from comparator `Greater`
- `cmp_equal` input 1: from comparator `Equal`
- `res_valid` output 1: result available
- `res_ready` input 1: consumer accepts result
- `res_flags` output 3: sampled flags, ordered {lesser, greater, equal}
- `res_error` output 1: sampled flags are not one-hot, or they disagree with the expected result
- `res_a` output N: operand a of the result
- `res_b` output N: operand b of the result
- `cnt_lesser` output CW: expected a<b count
- `cnt_greater` output CW: expected a>b count
- `cnt_equal` output CW: expected a==b count
- `cnt_error` output CW: mismatch count
- `clear` input 1: synchronous counter clear
- `busy` output 1: state ≠ IDLE or FIFO non-empty

## Operation
- FIFO behaviour:
  - Push occurs on `in_valid && in_ready`.
  - `in_ready = (count != DEPTH)`.
  - When the FIFO is full, a pop frees a slot, but `in_ready` stays low until the next cycle.
- FSM states: IDLE, SETTLE, PRESENT.
- IDLE → SETTLE, when the FIFO is non-empty:
  - Pop the head into `cmp_a`/`cmp_b`.
  - Load the settle counter with SETTLE-1.
- SETTLE:
  - If the counter is non-zero, decrement it.
  - If the counter is 0, perform the sample at this edge and go to PRESENT. The sample does the following:
    - Register `res_flags`, `res_a` and `res_b`.
    - Compute the expected result as an unsigned N-bit compare.
    - Set `res_error` = (flags ≠ expected one-hot).
    - Increment the counter for the expected outcome, and increment `cnt_error` when there is a mismatch.
- PRESENT:
  - `res_valid` = 1, and the result registers hold steady.
  - On `res_ready`, `res_valid` falls and the FSM returns to IDLE. IDLE always costs one bubble cycle.
- `cmp_a`/`cmp_b` keep their last values outside SETTLE.
- Counters saturate at 2^CW-1 and never wrap.
- `clear` zeroes all four counters. If `clear` coincides with a sample edge, clear wins and that sample is not counted. The result is still presented.
- A push while the FIFO is not full is accepted in any state.

## Timing
- Reset values: every output is 0 except `in_ready` = 1. The FIFO is empty and the FSM is in IDLE.
- Reset asserted mid-operation discards the in-flight pair and all FIFO contents. No result is emitted for discarded pairs.
- Latency, for a pair accepted at edge k with the FIFO empty and the FSM in IDLE:
  - Pop happens at edge k+1.
  - Sample happens at edge k+1+SETTLE.
  - `res_valid` is high after that sample edge, so total latency is SETTLE+1 edges.
- Operands are stable on `cmp_a`/`cmp_b` for exactly SETTLE full cycles before the sample edge.
- Throughput with `res_ready` held high is one pair per SETTLE+2 cycles.
- `res_valid` must not drop until a handshake occurs. Its payload must not change while it is high.
- The comparator is combinational. Flags are sampled only at the final SETTLE edge.

## Test plan
- Equal pair: after reset, push (2,2) with `res_ready` = 1 and SETTLE=2 → `res_valid` rises 3 edges after acceptance, `res_flags` = 3'b001, `res_error` = 0, `cnt_equal` = 1.
- Back-to-back push of (22,444), (444,555), (777,111), (8888,8888) → results in that order:
  - `res_flags` = 100, 100, 010, 001.
  - Final counts: `cnt_lesser` = 2, `cnt_greater` = 1, `cnt_equal` = 1, `cnt_error` = 0.
- Fault injection: force `cmp_greater` = 1 during (5,9) → `res_flags` = 3'b110, `res_error` = 1, `cnt_lesser` = 1, `cnt_error` = 1.
- Backpressure with `res_ready` = 0, push 6 pairs:
  - Expected: 5 pairs accepted (1 in flight, 4 in FIFO), then `in_ready` = 0.
  - Then raise `res_ready`: all 5 results emerge in order, and the 6th pair is accepted once a slot frees.
- Saturation and clear with CW=2: push 5 equal pairs → `cnt_equal` = 3. Pulse `clear` on a sample edge → all counters read 0 and that sample is not counted.
- Reset mid-SETTLE: assert `rst_n` = 0 during SETTLE with 2 pairs queued → all outputs are 0 and `in_ready` = 1 after release, and no `res_valid` appears without new pushes.

Source files
------------

// File: rtl/cmp_pair_sequencer.sv
// Drives operand pairs from a small FIFO onto an external combinational comparator,
// samples its flags after a programmable settle time, checks them and keeps statistics.
module cmp_pair_sequencer #(
  parameter int N      = 32,
  parameter int DEPTH  = 4,
  parameter int SETTLE = 2,
  parameter int CW     = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_a,
  input  logic [N-1:0]  in_b,
  output logic [N-1:0]  cmp_a,
  output logic [N-1:0]  cmp_b,
  input  logic          cmp_lesser,
  input  logic          cmp_greater,
  input  logic          cmp_equal,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [2:0]    res_flags,
  output logic          res_error,
  output logic [N-1:0]  res_a,
  output logic [N-1:0]  res_b,
  output logic [CW-1:0] cnt_lesser,
  output logic [CW-1:0] cnt_greater,
  output logic [CW-1:0] cnt_equal,
  output logic [CW-1:0] cnt_error,
  input  logic          clear,
  output logic          busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [AW:0]    FULL       = (AW + 1)'(DEPTH);
  localparam logic [SW-1:0]  SETTLE_LD  = SW'(SETTLE - 1);
  localparam logic [CW-1:0]  CNT_MAX    = '1;

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_PRESENT} state_t;

  state_t         state, state_next;
  logic [N-1:0]   mem_a [DEPTH];
  logic [N-1:0]   mem_b [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [AW:0]    count;
  logic [SW-1:0]  settle_cnt;
  logic           push, pop, sample;
  logic [2:0]     flags, exp_flags;
  logic           mismatch;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  assign in_ready  = (count != FULL);
  assign push      = in_valid && in_ready;
  assign res_valid = (state == S_PRESENT);
  assign busy      = (state != S_IDLE) || (count != '0);

  assign flags     = {cmp_lesser, cmp_greater, cmp_equal};
  assign exp_flags = (cmp_a < cmp_b) ? 3'b100 : (cmp_a > cmp_b) ? 3'b010 : 3'b001;
  assign mismatch  = (flags != exp_flags);

  // NOTE: storage arrays carry no reset; validity is tracked by the reset pointers/count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr] <= in_a;
      mem_b[wr_ptr] <= in_b;
    end
  end

  // NOTE: all clocked state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    sample     = 1'b0;
    case (state)
      S_IDLE: begin
        if (count != '0) begin
          pop        = 1'b1;
          state_next = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (settle_cnt == '0) begin
          sample     = 1'b1;
          state_next = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (res_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_a      <= '0;
      cmp_b      <= '0;
      settle_cnt <= '0;
      res_flags  <= '0;
      res_error  <= 1'b0;
      res_a      <= '0;
      res_b      <= '0;
    end else begin
      if (pop) begin
        cmp_a      <= mem_a[rd_ptr];
        cmp_b      <= mem_b[rd_ptr];
        settle_cnt <= SETTLE_LD;
      end else if (state == S_SETTLE && settle_cnt != '0) begin
        settle_cnt <= settle_cnt - 1'b1;
      end
      if (sample) begin
        res_flags <= flags;
        res_error <= mismatch;
        res_a     <= cmp_a;
        res_b     <= cmp_b;
      end
    end
  end

  // Statistics follow the expected outcome; a coincident clear discards the sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_lesser  <= '0;
      cnt_greater <= '0;
      cnt_equal   <= '0;
      cnt_error   <= '0;
    end else if (clear) begin
      cnt_lesser  <= '0;
      cnt_greater <= '0;
      cnt_equal   <= '0;
      cnt_error   <= '0;
    end else if (sample) begin
      if (exp_flags[2]) cnt_lesser  <= sat_inc(cnt_lesser);
      if (exp_flags[1]) cnt_greater <= sat_inc(cnt_greater);
      if (exp_flags[0]) cnt_equal   <= sat_inc(cnt_equal);
      if (mismatch)     cnt_error   <= sat_inc(cnt_error);
    end
  end

endmodule

// File: tb/tb_cmp_pair_sequencer.sv
// Scoreboard bench for cmp_pair_sequencer: a comparator model with fault injection,
// directed scenarios plus randomized traffic, checked against a queue-based reference.
module tb_cmp_pair_sequencer;

  localparam int N      = 32;
  localparam int DEPTH  = 4;
  localparam int SETTLE = 2;
  localparam int CW     = 2;
  localparam int CMAX   = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [N-1:0]  in_a = '0, in_b = '0;
  logic [N-1:0]  cmp_a, cmp_b;
  logic          cmp_lesser, cmp_greater, cmp_equal;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [2:0]    res_flags;
  logic          res_error;
  logic [N-1:0]  res_a, res_b;
  logic [CW-1:0] cnt_lesser, cnt_greater, cnt_equal, cnt_error;
  logic          clear = 1'b0;
  logic          busy;

  logic fault_g  = 1'b0;
  logic rr_rand  = 1'b0;
  logic rr_fixed = 1'b0;
  logic count_en = 1'b1;

  int checks = 0;
  int errors = 0;
  int m_l = 0, m_g = 0, m_e = 0, m_err = 0;

  typedef struct {
    logic [2:0]   flags;
    logic         err;
    logic [N-1:0] a;
    logic [N-1:0] b;
  } exp_t;
  exp_t sb[$];

  cmp_pair_sequencer #(.N(N), .DEPTH(DEPTH), .SETTLE(SETTLE), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .cmp_a(cmp_a), .cmp_b(cmp_b),
    .cmp_lesser(cmp_lesser), .cmp_greater(cmp_greater), .cmp_equal(cmp_equal),
    .res_valid(res_valid), .res_ready(res_ready), .res_flags(res_flags),
    .res_error(res_error), .res_a(res_a), .res_b(res_b),
    .cnt_lesser(cnt_lesser), .cnt_greater(cnt_greater),
    .cnt_equal(cnt_equal), .cnt_error(cnt_error),
    .clear(clear), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural comparator with a stuck-high fault on the greater flag.
  assign cmp_lesser  = (cmp_a < cmp_b);
  assign cmp_greater = (cmp_a > cmp_b) || fault_g;
  assign cmp_equal   = (cmp_a == cmp_b);

  always @(posedge clk) begin
    #1;
    res_ready = rr_rand ? 1'($urandom_range(0, 1)) : rr_fixed;
  end

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v < CMAX) ? v + 1 : v;
  endfunction

  // Reference: what a correct sampler reports for this pair under the current fault setting.
  task automatic model_push(input logic [N-1:0] a, input logic [N-1:0] b);
    exp_t e;
    logic [2:0] truth;
    truth   = (a < b) ? 3'b100 : (a > b) ? 3'b010 : 3'b001;
    e.flags = {a < b, (a > b) || fault_g, a == b};
    e.err   = (e.flags != truth);
    e.a     = a;
    e.b     = b;
    sb.push_back(e);
    if (count_en) begin
      if (truth[2]) m_l = sat(m_l);
      if (truth[1]) m_g = sat(m_g);
      if (truth[0]) m_e = sat(m_e);
      if (e.err)    m_err = sat(m_err);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_result", res_valid, 1'b0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("res_flags", res_flags, e.flags);
        check("res_error", res_error, e.err);
        check("res_operands", {res_a, res_b}, {e.a, e.b});
      end
    end
  end

  task automatic push(input logic [N-1:0] a, input logic [N-1:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("push_timeout", in_ready, 1'b1);
      @(posedge clk);
    end else begin
      @(posedge clk);
      model_push(a, b);
    end
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((busy || sb.size() != 0) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    if (busy || sb.size() != 0) check("drain_timeout", {busy, 32'(sb.size())}, '0);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    m_l = 0; m_g = 0; m_e = 0; m_err = 0;
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_cnt_lesser"},  cnt_lesser,  72'(m_l));
    check({tag, "_cnt_greater"}, cnt_greater, 72'(m_g));
    check({tag, "_cnt_equal"},   cnt_equal,   72'(m_e));
    check({tag, "_cnt_error"},   cnt_error,   72'(m_err));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_cmp"}, {cmp_a, cmp_b}, '0);
    check({tag, "_res"}, {res_a, res_b}, '0);
    check({tag, "_ctl"}, {res_valid, res_flags, res_error, busy, in_ready}, 72'b0000001);
    check({tag, "_cnt"}, {cnt_lesser, cnt_greater, cnt_equal, cnt_error}, '0);
  endtask

  initial begin
    logic [N-1:0] a, b;
    int mode;

    // Reset state
    repeat (3) @(negedge clk);
    check_reset_state("rst_held");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_reset_state("rst_rel");

    // Equal pair with latency check
    rr_fixed = 1'b1;
    @(posedge clk);
    #1;
    push(32'd2, 32'd2);
    for (int i = 0; i < SETTLE + 1; i++) begin
      @(negedge clk);
      check("latency_low", res_valid, 1'b0);
    end
    @(negedge clk);
    check("latency_high", res_valid, 1'b1);
    drain();
    check_counts("equal");

    // Back-to-back ordering
    pulse_clear();
    push(32'd22, 32'd444);
    push(32'd444, 32'd555);
    push(32'd777, 32'd111);
    push(32'd8888, 32'd8888);
    drain();
    check_counts("b2b");

    // Fault injection: greater stuck high
    pulse_clear();
    fault_g = 1'b1;
    push(32'd5, 32'd9);
    drain();
    fault_g = 1'b0;
    check_counts("fault");

    // Backpressure: five accepted, sixth waits for a slot
    pulse_clear();
    rr_fixed = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) push(32'(100 + i), 32'(200 - i));
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("bp_full", {in_ready, res_valid, 32'(sb.size())}, {1'b0, 1'b1, 32'd5});
    rr_fixed = 1'b1;
    push(32'd7, 32'd7);
    drain();
    check_counts("bp");

    // Saturation, then clear on a sample edge
    pulse_clear();
    for (int i = 0; i < 5; i++) push(32'(i * 3), 32'(i * 3));
    drain();
    check_counts("sat");
    check("sat_value", cnt_equal, 72'(CMAX));
    count_en = 1'b0;
    push(32'd1, 32'd2);
    repeat (SETTLE) @(posedge clk);
    #1;
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    count_en = 1'b1;
    m_l = 0; m_g = 0; m_e = 0; m_err = 0;
    drain();
    check_counts("clr_sample");

    // Reset in the middle of SETTLE with two pairs queued
    rr_fixed = 1'b0;
    @(posedge clk);
    #1;
    push(32'd10, 32'd20);
    push(32'd30, 32'd20);
    push(32'd40, 32'd40);
    rst_n = 1'b0;
    sb.delete();
    m_l = 0; m_g = 0; m_e = 0; m_err = 0;
    #1;
    check_reset_state("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    rr_fixed = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check_reset_state("rst_after");

    // Randomized rounds with random backpressure and occasional faults
    rr_rand = 1'b1;
    for (int r = 0; r < 4; r++) begin
      pulse_clear();
      fault_g = r[0];
      for (int i = 0; i < 12; i++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
        mode = $urandom_range(0, 3);
        a = $urandom();
        b = $urandom();
        case (mode)
          0: b = a;
          1: begin a = 32'($urandom_range(0, 3)); b = 32'($urandom_range(0, 3)); end
          2: begin a = '1; b = (b[0]) ? '0 : '1; end
          default: ;
        endcase
        push(a, b);
      end
      drain();
      check_counts("rand");
    end
    fault_g = 1'b0;
    rr_rand = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
